// File: rtl/add_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : add_sequencer_if
// Description : Request/response handshake bundle for add_sequencer.
// Revision    : 1.0
// ============================================================================
interface add_sequencer_if #(
    parameter int N     = 8,
    parameter int WORDS = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [N*WORDS-1:0] a;
    logic [N*WORDS-1:0] b;
    logic               cin;
    logic               sub;
    logic               out_valid;
    logic               out_ready;
    logic [N*WORDS-1:0] sum;
    logic               cout;
    logic               overflow;
    logic               busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : add_sequencer
// Description : Wide adder/subtractor built from one N-bit slice, LSB word first.
// Revision    : 1.0
// ============================================================================
module add_sequencer #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    add_sequencer_if.slave bus
);
    localparam int              W      = N * WORDS;
    localparam int              IDX_W  = $clog2(WORDS);
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(WORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;

    logic [N-1:0]     w_x, w_y, w_s;
    logic             w_cmsb, w_cout, w_last;
    logic             w_in_ready, w_out_valid, w_busy;

    assign w_last = (idx_q == c_LAST);
    assign w_x    = a_q[idx_q*N +: N];
    assign w_y    = b_q[idx_q*N +: N];

    // Shared slice: generate/propagate carry chain; the carry into the top
    // bit is kept separately for the signed overflow flag.
    always_comb begin
        logic v_c;
        w_s    = '0;
        w_cmsb = 1'b0;
        v_c    = carry_q;
        for (int i = 0; i < N; i++) begin
            w_s[i] = w_x[i] ^ w_y[i] ^ v_c;
            if (i == N - 1) begin
                w_cmsb = v_c;
            end
            v_c = (w_x[i] & w_y[i]) | ((w_x[i] ^ w_y[i]) & v_c);
        end
        w_cout = v_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (bus.in_valid)  state_d = c_RUN;
            c_RUN:   if (w_last)        state_d = c_DONE;
            c_DONE:  if (bus.out_ready) state_d = c_IDLE;
            default:                    state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (state_q == c_IDLE);
        w_out_valid = (state_q == c_DONE);
        w_busy      = (state_q != c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub | bus.cin;
                        idx_q   <= '0;
                    end
                end
                c_RUN: begin
                    sum_q[idx_q*N +: N] <= w_s;
                    carry_q             <= w_cout;
                    if (w_last) begin
                        cout_q <= w_cout;
                        ovf_q  <= w_cmsb ^ w_cout;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_sequencer
// Description : Directed vector bench for add_sequencer at N=8, WORDS=4.
// Revision    : 1.0
// ============================================================================
module tb_add_sequencer;
    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int LAT   = WORDS + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    add_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

    add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bb;
        logic [32:0] r;
        logic        ovf;
        bb  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
        ovf = (a[31] == bb[31]) && (r[31] != a[31]);
        return {ovf, r[32], r[31:0]};
    endfunction

    // Issues one request from IDLE and waits (bounded) for out_valid; operands
    // are scrambled during RUN to show they are not re-sampled.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, output int lat);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.cin      = ~cin;
        bus.sub      = ~sub;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_result;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[11];
        int          lat;
        logic [31:0] hs;
        logic        hc, ho;
        logic [33:0] expq[$];
        logic [33:0] e;
        int          last_acc;
        logic        acc;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5]  = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[7]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{32'h00000010, 32'h00000003, 1'b0, 1'b1, 32'h0000000D, 1'b1, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[10] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_busy",      64'(bus.busy),      64'd0);
        check("reset_sum",       64'(bus.sum),       64'd0);
        check("reset_cout",      64'(bus.cout),      64'd0);
        check("reset_ovf",       64'(bus.overflow),  64'd0);

        for (int i = 0; i < 11; i++) begin
            check($sformatf("vec%0d_idle_ready", i), 64'(bus.in_ready), 64'd1);
            run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat),          64'(LAT));
            check($sformatf("vec%0d_sum", i),     64'(bus.sum),      64'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i),    64'(bus.cout),     64'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i),     64'(bus.overflow), 64'(vecs[i].ovf));
            release_result();
        end

        // Result held while the consumer stalls; requests in DONE are ignored.
        run_txn(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, lat);
        hs = bus.sum;
        hc = bus.cout;
        ho = bus.overflow;
        check("hold_sum_value", 64'(hs), 64'h10101010);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            tick();
            check($sformatf("hold%0d_out_valid", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("hold%0d_in_ready", k),  64'(bus.in_ready),  64'd0);
            check($sformatf("hold%0d_sum", k),       64'(bus.sum),       64'(hs));
            check($sformatf("hold%0d_cout", k),      64'(bus.cout),      64'(hc));
            check($sformatf("hold%0d_ovf", k),       64'(bus.overflow),  64'(ho));
        end
        bus.in_valid = 1'b0;
        release_result();
        check("hold_release_in_ready",  64'(bus.in_ready),  64'd1);
        check("hold_release_out_valid", 64'(bus.out_valid), 64'd0);

        // Reset at RUN idx=2 abandons the operation.
        bus.a        = 32'hFFFFFFFF;
        bus.b        = 32'hFFFFFFFF;
        bus.cin      = 1'b1;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("midrun_busy", 64'(bus.busy), 64'd1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("midrun_rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrun_rst_busy",      64'(bus.busy),      64'd0);
        check("midrun_rst_sum",       64'(bus.sum),       64'd0);
        check("midrun_rst_cout",      64'(bus.cout),      64'd0);
        check("midrun_rst_ovf",       64'(bus.overflow),  64'd0);
        run_txn(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
        check("after_rst_latency", 64'(lat),     64'(LAT));
        check("after_rst_sum",     64'(bus.sum), 64'h01000000);
        release_result();

        // Reset while DONE drops out_valid with no further pulse.
        run_txn(32'h00000003, 32'h00000004, 1'b0, 1'b0, lat);
        check("middone_sum", 64'(bus.sum), 64'h7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("middone_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("middone_rst_sum",       64'(bus.sum),       64'd0);
        tick();
        check("middone_no_pulse", 64'(bus.out_valid), 64'd0);

        // Back-to-back stream: in_valid and out_ready held high.
        last_acc      = -1;
        bus.a         = 32'hDEADBEEF;
        bus.b         = 32'h12345678;
        bus.cin       = 1'b1;
        bus.sub       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = 1'b0;
            if (bus.in_ready) begin
                expq.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
                if (last_acc >= 0) begin
                    check("b2b_spacing", 64'(cyc - last_acc), 64'(WORDS + 2));
                end
                last_acc = cyc;
                acc      = 1'b1;
            end
            tick();
            if (acc) begin
                bus.a   = $urandom;
                bus.b   = $urandom;
                bus.cin = 1'($urandom_range(0, 1));
                bus.sub = 1'($urandom_range(0, 1));
            end
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    check("b2b_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("b2b_result", {30'd0, bus.overflow, bus.cout, bus.sum}, 64'(e));
                end
            end
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 20 && expq.size() != 0; k++) begin
            tick();
            if (bus.out_valid) begin
                e = expq.pop_front();
                check("b2b_drain_result", {30'd0, bus.overflow, bus.cout, bus.sum}, 64'(e));
            end
        end
        check("b2b_all_results_seen", 64'(expq.size()), 64'd0);
        bus.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
